// File: rtl/crop_stream_arbiter.sv
// -----------------------------------------------------------------------------
// crop_stream_arbiter
//
// Frame-granular round-robin scheduler that time-shares one crop_plus_fifo
// core between NUM_SRC raster pixel streams. A source is granted the core for
// one full IN_ROWS*IN_COLS input frame. The core's cropped output is passed
// straight through, tagged with the granted source id and a last-beat flag.
// Only one frame is ever resident in the core, so every output beat belongs
// to the current grant.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   s_pixel_in        : NUM_SRC packed pixels, source i in slice i
//   s_in_valid        : per-source valid
//   s_in_ready        : per-source ready (only the granted source, in FEED)
//   core_pixel_in     : pixel to the core
//   core_in_valid     : valid to the core
//   core_in_ready     : ready from the core
//   core_pixel_out    : cropped pixel from the core
//   core_out_valid    : valid from the core
//   core_out_ready    : ready to the core
//   pixel_out         : cropped pixel to downstream
//   out_valid         : output valid
//   out_ready         : downstream ready
//   out_src           : source id of the current output beat
//   out_last          : final beat of a crop
//   busy              : arbiter is not IDLE
//   proto_err         : sticky, core_out_valid was seen while IDLE
// -----------------------------------------------------------------------------
module crop_stream_arbiter #(
    parameter int PIXEL_BIT_WIDTH = 12,
    parameter int NUM_SRC         = 4,
    parameter int IN_ROWS         = 40,
    parameter int IN_COLS         = 40,
    parameter int OUT_ROWS        = 20,
    parameter int OUT_COLS        = 20,
    parameter int SRC_W           = $clog2(NUM_SRC)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_SRC*PIXEL_BIT_WIDTH-1:0] s_pixel_in,
    input  logic [NUM_SRC-1:0]                 s_in_valid,
    output logic [NUM_SRC-1:0]                 s_in_ready,
    output logic [PIXEL_BIT_WIDTH-1:0]         core_pixel_in,
    output logic                               core_in_valid,
    input  logic                               core_in_ready,
    input  logic [PIXEL_BIT_WIDTH-1:0]         core_pixel_out,
    input  logic                               core_out_valid,
    output logic                               core_out_ready,
    output logic [PIXEL_BIT_WIDTH-1:0]         pixel_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [SRC_W-1:0]                   out_src,
    output logic                               out_last,
    output logic                               busy,
    output logic                               proto_err
);

    localparam int IN_BEATS  = IN_ROWS * IN_COLS;
    localparam int OUT_BEATS = OUT_ROWS * OUT_COLS;
    localparam int IN_CW     = $clog2(IN_BEATS + 1);
    localparam int OUT_CW    = $clog2(OUT_BEATS + 1);

    localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(IN_BEATS - 1);
    localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(OUT_BEATS - 1);
    // out_cnt parks here when the whole crop drained while still in FEED.
    localparam logic [OUT_CW-1:0] OUT_DONE = OUT_CW'(OUT_BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [SRC_W-1:0]    gnt_q, gnt_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IN_CW-1:0]    in_cnt_q, in_cnt_d;
    logic [OUT_CW-1:0]   out_cnt_q, out_cnt_d;
    logic                proto_err_q, proto_err_d;

    // Unpacked view of the source pixel bus so the granted slice is a plain
    // array index.
    logic [PIXEL_BIT_WIDTH-1:0] src_pix [NUM_SRC];
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src_pix
        assign src_pix[g] = s_pixel_in[g*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH];
    end

    // -------------------------------------------------------------------------
    // Round-robin pick: first requester after rr_ptr, wrapping modulo NUM_SRC.
    // -------------------------------------------------------------------------
    logic             req_any;
    logic [SRC_W-1:0] winner;

    always_comb begin : rr_pick
        logic [SRC_W-1:0] cand;
        // NOTE: every variable written in a combinational block gets a default
        // first; otherwise an unassigned path infers a latch.
        req_any = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = SRC_W'((int'(rr_ptr_q) + k) % NUM_SRC);
            if (!req_any && s_in_valid[cand]) begin
                req_any = 1'b1;
                winner  = cand;
            end
        end
    end

    logic in_fire;
    logic out_fire;

    assign in_fire  = core_in_valid & core_in_ready;
    assign out_fire = out_valid & out_ready;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rr_ptr_q    <= SRC_W'(NUM_SRC - 1);
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        proto_err_d = proto_err_q;

        unique case (state_q)
            IDLE: begin
                // No frame is resident, so the core has nothing to emit.
                if (core_out_valid) begin
                    proto_err_d = 1'b1;
                end
                if (req_any) begin
                    gnt_d    = winner;
                    rr_ptr_d = winner;
                    state_d  = FEED;
                end
            end

            FEED: begin
                if (in_fire) begin
                    if (in_cnt_q == IN_LAST) begin
                        in_cnt_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
                if (out_fire && (out_cnt_q != OUT_DONE)) begin
                    out_cnt_d = out_cnt_q + 1'b1;
                end
            end

            DRAIN: begin
                if ((out_fire && out_last) || (out_cnt_q == OUT_DONE)) begin
                    out_cnt_d = '0;
                    state_d   = IDLE;
                end else if (out_fire) begin
                    out_cnt_d = out_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: input mux in FEED, zero-latency output pass-through in
    // FEED and DRAIN. out_src is stable across stalls since gnt only moves in
    // IDLE.
    // -------------------------------------------------------------------------
    always_comb begin
        s_in_ready     = '0;
        core_in_valid  = 1'b0;
        core_pixel_in  = src_pix[gnt_q];
        core_out_ready = 1'b0;
        out_valid      = 1'b0;
        out_last       = 1'b0;
        pixel_out      = core_pixel_out;
        out_src        = gnt_q;

        if (state_q == FEED) begin
            core_in_valid     = s_in_valid[gnt_q];
            s_in_ready[gnt_q] = core_in_ready;
        end

        if (state_q != IDLE) begin
            out_valid      = core_out_valid;
            core_out_ready = out_ready;
            out_last       = core_out_valid && (out_cnt_q == OUT_LAST);
        end
    end

    assign busy      = (state_q != IDLE);
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_crop_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_crop_stream_arbiter
//
// Drives crop_stream_arbiter against a small behavioural centre-crop core.
// Expected crop beats (pixel, source, last) are queued when a frame is
// scheduled; an independent monitor pops and compares each accepted output.
// -----------------------------------------------------------------------------
module tb_crop_stream_arbiter;

    localparam int W        = 12;
    localparam int NS       = 4;
    localparam int IR       = 40;
    localparam int IC       = 40;
    localparam int OR       = 20;
    localparam int OC       = 20;
    localparam int SW       = 2;
    localparam int IN_BEATS = IR * IC;
    localparam int R0       = (IR - OR) / 2;
    localparam int C0       = (IC - OC) / 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NS*W-1:0] s_pixel_in;
    logic [NS-1:0]   s_in_valid;
    logic [NS-1:0]   s_in_ready;
    logic [W-1:0]    core_pixel_in;
    logic            core_in_valid;
    logic            core_in_ready;
    logic [W-1:0]    core_pixel_out;
    logic            core_out_valid;
    logic            core_out_ready;
    logic [W-1:0]    pixel_out;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_src;
    logic            out_last;
    logic            busy;
    logic            proto_err;

    always #5 clk = ~clk;

    crop_stream_arbiter #(
        .PIXEL_BIT_WIDTH(W),
        .NUM_SRC        (NS),
        .IN_ROWS        (IR),
        .IN_COLS        (IC),
        .OUT_ROWS       (OR),
        .OUT_COLS       (OC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_pixel_in    (s_pixel_in),
        .s_in_valid    (s_in_valid),
        .s_in_ready    (s_in_ready),
        .core_pixel_in (core_pixel_in),
        .core_in_valid (core_in_valid),
        .core_in_ready (core_in_ready),
        .core_pixel_out(core_pixel_out),
        .core_out_valid(core_out_valid),
        .core_out_ready(core_out_ready),
        .pixel_out     (pixel_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_src       (out_src),
        .out_last      (out_last),
        .busy          (busy),
        .proto_err     (proto_err)
    );

    // ---------------------------------------------------------------- checking
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit in_window(input int pos);
        int r;
        int c;
        r = pos / IC;
        c = pos % IC;
        return (r >= R0) && (r < R0 + OR) && (c >= C0) && (c < C0 + OC);
    endfunction

    // Source s, frame index k. Source 0 carries the raw index.
    function automatic logic [W-1:0] pix(input int src, input int k);
        return W'((k + src * 256) % 4096);
    endfunction

    // ------------------------------------------------------ behavioural core
    logic [W-1:0] core_mem [0:1023];
    logic [10:0]  wr_ptr   = '0;
    logic [10:0]  rd_ptr   = '0;
    int           core_pos = 0;
    logic         force_ov = 1'b0;

    assign core_in_ready  = 1'b1;
    assign core_out_valid = force_ov || (wr_ptr != rd_ptr);
    assign core_pixel_out = core_mem[rd_ptr[9:0]];

    always @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            core_pos <= 0;
        end else begin
            if (core_in_valid && core_in_ready) begin
                if (in_window(core_pos)) begin
                    core_mem[wr_ptr[9:0]] <= core_pixel_in;
                    wr_ptr <= wr_ptr + 1'b1;
                end
                core_pos <= (core_pos == IN_BEATS - 1) ? 0 : core_pos + 1;
            end
            if (core_out_valid && core_out_ready && (wr_ptr != rd_ptr)) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------- scoreboard
    typedef struct {
        logic [W-1:0]  pix;
        logic [SW-1:0] src;
        logic          last;
    } exp_t;

    exp_t exp_q[$];

    task automatic expect_frame(input int src);
        exp_t e;
        int   n = 0;
        for (int k = 0; k < IN_BEATS; k++) begin
            if (in_window(k)) begin
                n++;
                e.pix  = pix(src, k);
                e.src  = SW'(src);
                e.last = (n == OR * OC);
                exp_q.push_back(e);
            end
        end
    endtask

    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_pix;
    logic [SW-1:0] prev_src;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_pixel", 32'(pixel_out), 32'(prev_pix));
                check("hold_src", 32'(out_src), 32'(prev_src));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got pixel %0d src %0d, expected no beat", pixel_out, out_src);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pixel", 32'(pixel_out), 32'(e.pix));
                    check("out_src", 32'(out_src), 32'(e.src));
                    check("out_last", 32'(out_last), 32'(e.last));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_pix   = pixel_out;
            prev_src   = out_src;
        end
    end

    // ---------------------------------------------------------------- driver
    int frames_left [NS];
    int idx         [NS];
    bit rand_mode;
    int idle_cnt;

    function automatic bit frames_pending();
        for (int i = 0; i < NS; i++) begin
            if (frames_left[i] > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic run(input int budget);
        int cyc = 0;
        idle_cnt = 0;
        while ((frames_pending() || exp_q.size() != 0) && cyc < budget) begin
            for (int i = 0; i < NS; i++) begin
                s_pixel_in[i*W +: W] = pix(i, idx[i]);
                s_in_valid[i] = (frames_left[i] > 0) && (!rand_mode || $urandom_range(0, 1) == 1);
            end
            out_ready = !rand_mode || ($urandom_range(0, 1) == 1);
            @(negedge clk);
            check("ready_onehot", 32'($onehot0(s_in_ready)), 32'd1);
            if (!busy) begin
                check("idle_ready", 32'(s_in_ready), 32'd0);
                check("idle_out_valid", 32'(out_valid), 32'd0);
                if (frames_pending()) idle_cnt++;
            end
            for (int i = 0; i < NS; i++) begin
                if (s_in_valid[i] && s_in_ready[i]) begin
                    idx[i]++;
                    if (idx[i] == IN_BEATS) begin
                        idx[i] = 0;
                        frames_left[i]--;
                    end
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        s_in_valid = '0;
        out_ready  = 1'b1;
        check("run_in_budget", 32'(cyc < budget), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int cyc = 0;
        while (busy && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("busy_fall", 32'(busy), 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    initial begin
        int cyc;
        reset      = 1'b1;
        s_pixel_in = '0;
        s_in_valid = 4'hF;
        out_ready  = 1'b1;
        rand_mode  = 1'b0;
        for (int i = 0; i < NS; i++) begin
            frames_left[i] = 0;
            idx[i]         = 0;
        end

        // Reset holds everything quiet even with every source requesting.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s_in_ready", 32'(s_in_ready), 32'd0);
        check("rst_core_in_valid", 32'(core_in_valid), 32'd0);
        check("rst_core_out_ready", 32'(core_out_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        s_in_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single source 0, full-rate: crop 410..429 ... 1170..1189.
        frames_left[0] = 1;
        expect_frame(0);
        run(4000);
        check("t1_idle_cycles", 32'(idle_cnt), 32'd1);
        wait_idle(10);

        // All sources, two frames each, from reset pointer: 0,1,2,3,0,1,2,3.
        pulse_reset();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < NS; i++) expect_frame(i);
        end
        for (int i = 0; i < NS; i++) frames_left[i] = 2;
        run(15000);
        check("t2_idle_cycles", 32'(idle_cnt), 32'd8);
        wait_idle(10);

        // Source 2 with random valid and random downstream ready.
        rand_mode      = 1'b1;
        frames_left[2] = 1;
        expect_frame(2);
        run(12000);
        rand_mode = 1'b0;
        wait_idle(2000);

        // Sources 1 and 3 after a grant to 2: 3, then 1, then 3 again.
        frames_left[1] = 1;
        frames_left[3] = 2;
        expect_frame(3);
        expect_frame(1);
        expect_frame(3);
        run(7000);
        check("t4_idle_cycles", 32'(idle_cnt), 32'd3);
        wait_idle(10);

        // Reset after 700 input beats of source 1, output stalled throughout.
        out_ready = 1'b0;
        idx[1]    = 0;
        cyc       = 0;
        while (idx[1] < 700 && cyc < 2000) begin
            s_pixel_in[1*W +: W] = pix(1, idx[1]);
            s_in_valid           = 4'b0010;
            @(negedge clk);
            if (s_in_valid[1] && s_in_ready[1]) idx[1]++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("t5_beats_before_reset", 32'(idx[1]), 32'd700);
        check("t5_busy_before_reset", 32'(busy), 32'd1);
        pulse_reset();
        @(negedge clk);
        check("t5_busy_after_reset", 32'(busy), 32'd0);
        check("t5_ready_after_reset", 32'(s_in_ready), 32'd0);
        check("t5_out_valid_after_reset", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        s_in_valid     = '0;
        out_ready      = 1'b1;
        idx[1]         = 0;
        frames_left[1] = 1;
        expect_frame(1);
        run(4000);
        wait_idle(10);

        // core_out_valid while IDLE raises a sticky proto_err.
        @(posedge clk);
        #1;
        force_ov = 1'b1;
        @(negedge clk);
        check("t6_out_valid_idle", 32'(out_valid), 32'd0);
        check("t6_core_out_ready_idle", 32'(core_out_ready), 32'd0);
        @(posedge clk);
        #1;
        force_ov = 1'b0;
        @(negedge clk);
        check("t6_proto_err_set", 32'(proto_err), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("t6_proto_err_sticky", 32'(proto_err), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);
        pulse_reset();
        @(negedge clk);
        check("t6_proto_err_cleared", 32'(proto_err), 32'd0);

        check("leftover_expected", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
